fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The parameter SHALL be: ADDR_W, default 8, instruction-memory address width.
REQ-002 The parameter SHALL be: NOP_OP, default 4'b1111, opcode issued for inserted bubbles.
REQ-003 The port SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-004 The port SHALL be: rst  in  1  synchronous, active-high reset.
REQ-005 The port SHALL be: start  in  1  one-cycle pulse that leaves IDLE.
REQ-006 The port SHALL be: stall  in  1  hazard hold from downstream; freezes PC and issue registers.
REQ-007 The port SHALL be: branch_taken  in  1  branch resolved taken (decoder branch AND compare flag).
REQ-008 The port SHALL be: branch_target  in  ADDR_W  new PC when branch_taken=1.
REQ-009 The port SHALL be: imem_addr  out  ADDR_W  fetch address, equal to the PC register.
REQ-010 The port SHALL be: imem_re  out  1  fetch enable; memory holds imem_rdata when 0.
REQ-011 The port SHALL be: imem_rdata  in  16  word for the address presented the previous cycle with imem_re=1.
REQ-012 The port SHALL be: opcode  out  4  issued opcode, drives the control decoder.
REQ-013 The port SHALL be: rd, ra, rb_imm  out  4 each  issued fields [11:8], [7:4], [3:0].
REQ-014 The port SHALL be: instr_valid  out  1  1 for program words, 0 for inserted bubbles.

Function
REQ-015 Instruction word SHALL be: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb/offset.
REQ-016 FSM states SHALL be IDLE, FILL, RUN; IDLE->FILL on start, FILL->RUN after one cycle, RUN holds until rst.
REQ-017 In IDLE: imem_re=0, PC=0, issue registers hold a bubble (opcode=NOP_OP, fields 0, instr_valid=0).
REQ-018 In FILL: imem_re=1, PC increments, issue registers load a bubble (first word not yet returned).
REQ-019 In RUN without stall/branch: imem_re=1, PC<=PC+1, issue registers <= imem_rdata with instr_valid=1.
REQ-020 Fetch-to-issue latency SHALL be 2 cycles: address at cycle t, issued outputs visible at t+2.
REQ-021 PC SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-022 stall=1 (no branch): imem_re=0, PC holds, all issue outputs hold; on release the held imem_rdata is issued next edge, with no word lost or duplicated.
REQ-023 branch_taken=1 in RUN: PC<=branch_target, issue registers load a bubble, and the next imem_rdata (wrong path) SHALL also be replaced by a bubble: exactly 2 bubbles, then the word at branch_target.
REQ-024 branch_taken SHALL have priority over stall in the same cycle; the squash count still applies after stall drops.
REQ-025 A second branch_taken during the squash cycle SHALL restart the redirect from its own target (2 fresh bubbles).
REQ-026 branch_taken and stall SHALL be ignored in IDLE and FILL.
REQ-027 A program NOP word SHALL be issued with instr_valid=1; only inserted bubbles carry instr_valid=0.

Reset
REQ-028 On rst (sampled high at an edge), next cycle SHALL show state=IDLE, PC=0, imem_re=0, opcode=NOP_OP, rd=ra=rb_imm=0, instr_valid=0, squash cleared, regardless of state mid-operation.
REQ-029 rst SHALL take priority over start, stall and branch_taken.

Structure
REQ-030 Opcode constants (CMP=1000, LD=1100, ST=1101, MOV=1011, NOT=0110, BT=1110, NOP=1111), field positions and the FSM state enum SHALL live in shared package proc_pkg.
REQ-031 The PC register with load/increment/hold/wrap SHALL be sub-module pc_reg; FSM, squash flag and issue registers stay in fetch_unit.

Verification
REQ-032 Reset then start, mem[i]=i*0x1111 (low 16 bits): bubbles while IDLE/FILL, then words 0x0000,0x1111,0x2222 issued on consecutive cycles with instr_valid=1.
REQ-033 stall high for 3 cycles while word at addr 5 is pending: imem_re=0, outputs frozen, PC frozen; after release addr 5 then 6 issued, none skipped or repeated.
REQ-034 branch_taken with target 0x40 while fetching addr 10: exactly 2 bubbles (opcode=1111, instr_valid=0), then mem[0x40], mem[0x41].
REQ-035 branch_taken and stall both high in one cycle: redirect to target proceeds; after stall release 2 bubbles then mem[target].
REQ-036 ADDR_W=8, run from PC=0xFE: issued 0xFE, 0xFF, 0x00, 0x01 in order.
REQ-037 rst asserted mid-RUN with squash pending: next cycle all REQ-028 values; no further issue until a new start.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field layout, fetch FSM
// states and the issued-instruction record.
package proc_pkg;

  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_BT  = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int RA_MSB     = 7;
  localparam int RA_LSB     = 4;
  localparam int RB_MSB     = 3;
  localparam int RB_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb_imm;
    logic       valid;
  } issue_t;

  // Inserted pipeline bubble: never confused with a program NOP because valid=0.
  function automatic issue_t make_bubble(input logic [3:0] nop_op);
    issue_t b;
    b.opcode = nop_op;
    b.rd     = 4'd0;
    b.ra     = 4'd0;
    b.rb_imm = 4'd0;
    b.valid  = 1'b0;
    return b;
  endfunction

  function automatic issue_t decode_word(input logic [INSTR_W-1:0] w);
    issue_t d;
    d.opcode = w[OPCODE_MSB:OPCODE_LSB];
    d.rd     = w[RD_MSB:RD_LSB];
    d.ra     = w[RA_MSB:RA_LSB];
    d.rb_imm = w[RB_MSB:RB_LSB];
    d.valid  = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous clear, load, increment with natural wrap, or hold.
module pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_reg_q;

  // Load beats increment; the adder simply rolls over at the top of memory.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pc_reg_q <= '0;
    end else if (load) begin
      pc_reg_q <= load_val;
    end else if (inc) begin
      pc_reg_q <= pc_reg_q + ONE;
    end
  end

  assign pc = pc_reg_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/FILL/RUN sequencing, stall hold, and a
// two-bubble branch redirect that squashes the in-flight wrong-path word.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [3:0] NOP_OP = 4'b1111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_re,
  input  logic [15:0]       imem_rdata,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        ra,
  output logic [3:0]        rb_imm,
  output logic              instr_valid
);

  fetch_state_e state_reg, state_next;
  issue_t       issue_reg, issue_next;
  logic         squash_reg, squash_next;

  logic pc_clear;
  logic pc_load;
  logic pc_inc;
  logic redirect;
  logic hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_FILL;
      ST_FILL: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  // Branch outranks stall, so a redirect is never lost behind a hazard hold.
  assign redirect = (state_reg == ST_RUN) && branch_taken;
  assign hold     = (state_reg == ST_RUN) && stall && !branch_taken;

  always_comb begin
    imem_re     = 1'b0;
    pc_clear    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    issue_next  = make_bubble(NOP_OP);
    squash_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        pc_clear = 1'b1;
      end
      ST_FILL: begin
        imem_re = 1'b1;
        pc_inc  = 1'b1;
      end
      ST_RUN: begin
        if (redirect) begin
          imem_re     = 1'b1;
          pc_load     = 1'b1;
          squash_next = 1'b1;
        end else if (hold) begin
          // The memory keeps imem_rdata while imem_re=0, so nothing is lost.
          issue_next  = issue_reg;
          squash_next = squash_reg;
        end else begin
          imem_re = 1'b1;
          pc_inc  = 1'b1;
          if (!squash_reg) begin
            issue_next = decode_word(imem_rdata);
          end
        end
      end
      default: begin
        pc_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_reg  <= make_bubble(NOP_OP);
      squash_reg <= 1'b0;
    end else begin
      issue_reg  <= issue_next;
      squash_reg <= squash_next;
    end
  end

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .clear   (pc_clear),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_val(branch_target),
    .pc      (imem_addr)
  );

  assign opcode      = issue_reg.opcode;
  assign rd          = issue_reg.rd;
  assign ra          = issue_reg.ra;
  assign rb_imm      = issue_reg.rb_imm;
  assign instr_valid = issue_reg.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: per-cycle expectations are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  imem_addr;
  logic        imem_re;
  logic [15:0] imem_rdata = 16'h0000;
  logic [3:0]  opcode, rd, ra, rb_imm;
  logic        instr_valid;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int          cyc;
    logic [15:0] word;
    logic        valid;
    logic        re;
    logic [7:0]  addr;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [15:0] B = 16'hF000;

  fetch_unit #(.ADDR_W(8), .NOP_OP(4'b1111)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_re      (imem_re),
    .imem_rdata   (imem_rdata),
    .opcode       (opcode),
    .rd           (rd),
    .ra           (ra),
    .rb_imm       (rb_imm),
    .instr_valid  (instr_valid)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h1111);
  end

  always @(posedge clk) begin
    if (imem_re) imem_rdata <= mem[imem_addr];
    cyc <= cyc + 1;
  end

  // Monitor: checks every queued expectation belonging to the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({opcode, rd, ra, rb_imm} !== e.word || instr_valid !== e.valid) begin
          n_fail++;
          $display("FAIL issue cyc=%0d got=%h/v%b exp=%h/v%b", e.cyc,
                   {opcode, rd, ra, rb_imm}, instr_valid, e.word, e.valid);
        end
        n_checks++;
        if (imem_re !== e.re) begin
          n_fail++;
          $display("FAIL imem_re cyc=%0d got=%b exp=%b", e.cyc, imem_re, e.re);
        end
        n_checks++;
        if (imem_addr !== e.addr) begin
          n_fail++;
          $display("FAIL imem_addr cyc=%0d got=%h exp=%h", e.cyc, imem_addr, e.addr);
        end
        $display("cyc=%0d issue=%h v=%b re=%b addr=%h", e.cyc,
                 {opcode, rd, ra, rb_imm}, instr_valid, imem_re, imem_addr);
      end
    end
  end

  // Drive this cycle's inputs, optionally queue this cycle's expected outputs, advance.
  task automatic step(input logic r, input logic st, input logic sl, input logic br,
                      input logic [7:0] tgt, input logic chk, input logic [15:0] w,
                      input logic v, input logic re_e, input logic [7:0] a);
    exp_t e;
    rst = r;
    start = st;
    stall = sl;
    branch_taken = br;
    branch_target = tgt;
    if (chk) begin
      e.cyc = cyc;
      e.word = w;
      e.valid = v;
      e.re = re_e;
      e.addr = a;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    //   rst st sl br tgt    chk word     v  re addr
    step(1, 0, 0, 0, 8'h00, 0, B,       0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h33, 1, B,       0, 0, 8'h00); // IDLE ignores stall/branch
    step(0, 1, 0, 0, 8'h00, 1, B,       0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h33, 1, B,       0, 1, 8'h00); // FILL ignores stall/branch
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h01);
    step(0, 0, 0, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h02);
    step(0, 0, 0, 0, 8'h00, 1, 16'h1111, 1, 1, 8'h03);
    step(0, 0, 0, 0, 8'h00, 1, 16'h2222, 1, 1, 8'h04);
    step(0, 0, 0, 0, 8'h00, 1, 16'h3333, 1, 1, 8'h05);
    step(0, 0, 1, 0, 8'h00, 1, 16'h4444, 1, 0, 8'h06); // stall, word 5 pending
    step(0, 0, 1, 0, 8'h00, 1, 16'h4444, 1, 0, 8'h06);
    step(0, 0, 1, 0, 8'h00, 1, 16'h4444, 1, 0, 8'h06);
    step(0, 0, 0, 0, 8'h00, 1, 16'h4444, 1, 1, 8'h06);
    step(0, 0, 0, 0, 8'h00, 1, 16'h5555, 1, 1, 8'h07);
    step(0, 0, 0, 0, 8'h00, 1, 16'h6666, 1, 1, 8'h08);
    step(0, 0, 0, 0, 8'h00, 1, 16'h7777, 1, 1, 8'h09);
    step(0, 0, 0, 1, 8'h40, 1, 16'h8888, 1, 1, 8'h0A); // branch while fetching 10
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h40);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h41);
    step(0, 0, 0, 0, 8'h00, 1, 16'h4440, 1, 1, 8'h42);
    step(0, 0, 1, 1, 8'h80, 1, 16'h5551, 1, 1, 8'h43); // branch + stall together
    step(0, 0, 1, 0, 8'h00, 1, B,       0, 0, 8'h80);
    step(0, 0, 1, 0, 8'h00, 1, B,       0, 0, 8'h80);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h80);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h81);
    step(0, 0, 0, 1, 8'h10, 1, 16'h8880, 1, 1, 8'h82);
    step(0, 0, 0, 1, 8'h20, 1, B,       0, 1, 8'h10); // re-branch during squash
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h20);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h21);
    step(0, 0, 0, 1, 8'hFE, 1, 16'h2220, 1, 1, 8'h22);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'hFE);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'hFF);
    step(0, 0, 0, 0, 8'h00, 1, 16'hEEDE, 1, 1, 8'h00); // PC wrapped
    step(0, 0, 0, 0, 8'h00, 1, 16'hFFEF, 1, 1, 8'h01); // program NOP opcode, valid
    step(0, 0, 0, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h02);
    step(0, 0, 0, 1, 8'h50, 1, 16'h1111, 1, 1, 8'h03);
    step(1, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h50); // reset with squash pending
    step(0, 0, 1, 1, 8'h22, 1, B,       0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00, 1, B,       0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00, 1, B,       0, 1, 8'h01);
    step(0, 0, 0, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h02); // squash was cleared
    step(0, 0, 0, 0, 8'h00, 1, 16'h1111, 1, 1, 8'h03);
    step(0, 0, 0, 0, 8'h00, 0, B,       0, 0, 8'h00);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
